// File: rtl/inst_fetch_pkg.sv
// Shared ISA-level constants and fetch-entry types for the instruction fetch slice.
// Word width, default reset vector and NOP encoding live here so every fetch file agrees.
package inst_fetch_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_VECTOR = 32'h0040_0000;
  localparam word_t NOP_INST     = 32'h0000_0000;

  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

  // PC arithmetic wraps modulo 2^32 with no overflow flag.
  function automatic word_t pc_plus4(input word_t pc);
    return pc + word_t'(4);
  endfunction

  function automatic word_t word_align(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Bus bundle between fetch, instruction memory, redirect source and decode.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  word_t       imemAddr;
  word_t       imemData;
  logic        redirectValid;
  word_t       redirectTarget;
  logic        outValid;
  logic        outReady;
  word_t       outInst;
  word_t       outPc;
  word_t       outPcPlus4;
  logic [31:0] fetchCount;

  modport master (
    output imemAddr,
    input  imemData,
    input  redirectValid,
    input  redirectTarget,
    output outValid,
    input  outReady,
    output outInst,
    output outPc,
    output outPcPlus4,
    output fetchCount
  );

  modport slave (
    input  imemAddr,
    output imemData,
    output redirectValid,
    output redirectTarget,
    input  outValid,
    output outReady,
    input  outInst,
    input  outPc,
    input  outPcPlus4,
    input  fetchCount
  );

endinterface

// File: rtl/FetchQueue.sv
// Circular FIFO of fetched {pc, inst} entries; a count register separates full from empty.
module FetchQueue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage needs no reset: the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register drives instruction memory, results are
// buffered in FetchQueue and handed to decode with a valid/ready handshake.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter word_t RESET_PC    = RESET_VECTOR,
  parameter int    QUEUE_DEPTH = 2
) (
  input logic        clk,
  input logic        reset_n,
  inst_fetch_if.master bus
);

  word_t        pc;
  logic [31:0]  fetch_cnt;
  logic         push;
  logic         pop;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign bus.imemAddr = pc;

  // A pop frees a slot in the same edge, so a full queue can still accept a push.
  assign pop      = !q_empty && bus.outReady;
  assign push     = !bus.redirectValid && (!q_full || pop);
  assign wr_entry = '{pc: pc, inst: bus.imemData};

  FetchQueue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (bus.redirectValid),
    .din     (wr_entry),
    .dout    (head),
    .full    (q_full),
    .empty   (q_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      fetch_cnt <= '0;
    end else if (bus.redirectValid) begin
      pc <= word_align(bus.redirectTarget);
    end else if (push) begin
      pc        <= pc_plus4(pc);
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

  // Head fields read as zero whenever nothing is valid.
  assign bus.outValid   = !q_empty;
  assign bus.outInst    = q_empty ? NOP_INST : head.inst;
  assign bus.outPc      = q_empty ? '0 : head.pc;
  assign bus.outPcPlus4 = q_empty ? '0 : pc_plus4(head.pc);
  assign bus.fetchCount = fetch_cnt;

endmodule
